// File: rtl/axi_lite_master_param.sv
// axi_lite_master_param: AXI4-Lite master behind a local transfer/busy/ready port.
// One transaction in flight, registered outputs, sticky watchdog flag.
module axi_lite_master_param #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RVALID,
  output logic                RREADY,
  input  logic                transfer,
  input  logic                write,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                busy,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          resp,
  output logic                timeout
);

  localparam int SW = DATA_W / 8;
  localparam int CW =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    IDLE, WR, WR_RESP, RD_ADDR, RD_DATA
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              awvalid_d, wvalid_d, bready_d;
  logic              arvalid_d, rready_d;
  logic [ADDR_W-1:0] awaddr_d, araddr_d;
  logic [DATA_W-1:0] wdata_d, rdata_d;
  logic [SW-1:0]     wstrb_d;
  logic              busy_d, ready_d, timeout_d;
  logic [1:0]        resp_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    awvalid_d = AWVALID;
    wvalid_d  = WVALID;
    bready_d  = BREADY;
    arvalid_d = ARVALID;
    rready_d  = RREADY;
    awaddr_d  = AWADDR;
    araddr_d  = ARADDR;
    wdata_d   = WDATA;
    wstrb_d   = WSTRB;
    busy_d    = busy;
    ready_d   = 1'b0;
    rdata_d   = rdata;
    resp_d    = resp;
    timeout_d = timeout;
    // watchdog saturates at TMAX; TIMEOUT_CYC=0 keeps it idle
    if (busy && cnt_q != TMAX)
      cnt_d = cnt_q + CW'(1);
    if (busy && cnt_d == TMAX && TIMEOUT_CYC != 0)
      timeout_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          awaddr_d  = addr;
          araddr_d  = addr;
          wdata_d   = wdata;
          wstrb_d   = wstrb;
          busy_d    = 1'b1;
          cnt_d     = '0;
          timeout_d = 1'b0;
          if (write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR: begin
        awvalid_d = AWVALID & ~AWREADY;
        wvalid_d  = WVALID & ~WREADY;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (BVALID) begin
          bready_d = 1'b0;
          resp_d   = BRESP;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_ADDR: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (RVALID) begin
          rready_d = 1'b0;
          rdata_d  = RDATA;
          resp_d   = RRESP;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      AWVALID <= 1'b0;
      WVALID  <= 1'b0;
      BREADY  <= 1'b0;
      ARVALID <= 1'b0;
      RREADY  <= 1'b0;
      AWADDR  <= '0;
      ARADDR  <= '0;
      WDATA   <= '0;
      WSTRB   <= '0;
      busy    <= 1'b0;
      ready   <= 1'b0;
      rdata   <= '0;
      resp    <= 2'b00;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      AWVALID <= awvalid_d;
      WVALID  <= wvalid_d;
      BREADY  <= bready_d;
      ARVALID <= arvalid_d;
      RREADY  <= rready_d;
      AWADDR  <= awaddr_d;
      ARADDR  <= araddr_d;
      WDATA   <= wdata_d;
      WSTRB   <= wstrb_d;
      busy    <= busy_d;
      ready   <= ready_d;
      rdata   <= rdata_d;
      resp    <= resp_d;
      timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_master_param.sv
// tb_axi_lite_master_param: random-delay AXI-Lite slave plus
// transaction-level expectations for the master.
module tb_axi_lite_master_param;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic [AW-1:0] AWADDR, ARADDR;
  logic          AWVALID, WVALID, BREADY;
  logic          ARVALID, RREADY;
  logic          AWREADY = 0, WREADY = 0;
  logic          BVALID = 0, ARREADY = 0;
  logic          RVALID = 0;
  logic [1:0]    BRESP = 0, RRESP = 0;
  logic [DW-1:0] WDATA, RDATA = 0;
  logic [3:0]    WSTRB;
  logic          transfer = 0, write = 0;
  logic [AW-1:0] addr = 0;
  logic [DW-1:0] wdata = 0;
  logic [3:0]    wstrb = 0;
  logic          busy, ready, timeout;
  logic [DW-1:0] rdata;
  logic [1:0]    resp;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] last_rdata = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_master_param #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID),
    .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB),
    .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID),
    .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP),
    .RVALID(RVALID), .RREADY(RREADY),
    .transfer(transfer), .write(write),
    .addr(addr), .wdata(wdata),
    .wstrb(wstrb),
    .busy(busy), .ready(ready),
    .rdata(rdata), .resp(resp),
    .timeout(timeout)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // da: AW/AR ready delay, dw: W ready delay,
  // dr: B/R valid delay after address phases done
  task automatic run_txn(
    input bit wr, input logic [AW-1:0] a,
    input logic [DW-1:0] d, input logic [3:0] s,
    input int da, input int dw, input int dr,
    input bit early_b, input bit hold,
    input logic [1:0] rsp, input logic [DW-1:0] rd);
    bit aw_done = 0, w_done = 0, both = 0;
    bit ar_done = 0, done = 0;
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r;
    int t_both = 0, t_ar = 0, e = 0;
    transfer = 1; write = wr; addr = a;
    wdata = d; wstrb = s;
    @(posedge ACLK); #1;
    while (!done) begin
      if (e > 200) begin
        chk("txn_bound", 0, 1);
        break;
      end
      chk("busy", busy, 1);
      chk("ready_low", ready, 0);
      chk("timeout", timeout, e >= TO);
      if (hold) begin
        transfer = 1; write = 1'($urandom);
        addr = AW'($urandom);
        wdata = $urandom; wstrb = 4'($urandom);
      end else transfer = 0;
      hs_aw = 0; hs_w = 0; hs_b = 0;
      hs_ar = 0; hs_r = 0;
      if (wr) begin
        chk("awvalid", AWVALID, !aw_done);
        chk("wvalid", WVALID, !w_done);
        chk("bready", BREADY, both);
        chk("arvalid_wr", ARVALID, 0);
        if (!aw_done) chk("awaddr", AWADDR, a);
        if (!w_done) begin
          chk("wdata", WDATA, d);
          chk("wstrb", WSTRB, s);
        end
        AWREADY = !aw_done && e >= da;
        WREADY = !w_done && e >= dw;
        BVALID = early_b ? 1'b1 :
                 (both && e >= t_both + dr);
        BRESP = rsp;
        hs_aw = AWREADY; hs_w = WREADY;
        hs_b = BVALID && both;
      end else begin
        chk("arvalid", ARVALID, !ar_done);
        chk("rready", RREADY, ar_done);
        chk("awvalid_rd", AWVALID, 0);
        if (!ar_done) chk("araddr", ARADDR, a);
        ARREADY = !ar_done && e >= da;
        RVALID = ar_done && e >= t_ar + dr;
        RDATA = rd; RRESP = rsp;
        hs_ar = ARREADY; hs_r = RVALID;
      end
      @(posedge ACLK); #1;
      e++;
      if (hs_aw) aw_done = 1;
      if (hs_w) w_done = 1;
      if (aw_done && w_done && !both) begin
        both = 1; t_both = e;
      end
      if (hs_ar) begin ar_done = 1; t_ar = e; end
      if (hs_b || hs_r) done = 1;
    end
    AWREADY = 0; WREADY = 0; BVALID = 0;
    ARREADY = 0; RVALID = 0; transfer = 0;
    chk("ready_pulse", ready, 1);
    chk("busy_done", busy, 0);
    chk("resp", resp, rsp);
    chk("rdata", rdata, wr ? last_rdata : rd);
    chk("timeout_done", timeout, e >= TO);
    chk("bready_off", BREADY, 0);
    chk("rready_off", RREADY, 0);
    if (!wr) last_rdata = rd;
  endtask

  bit            r_wr, r_eb, r_hold;
  int            r_da, r_dw, r_dr;
  logic [AW-1:0] r_a;
  logic [DW-1:0] r_d, r_rd;
  logic [3:0]    r_s;
  logic [1:0]    r_rsp;

  initial begin
    @(posedge ACLK); #1;
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", resp, 0);
    chk("rst_awaddr", AWADDR, 0);
    chk("rst_araddr", ARADDR, 0);
    chk("rst_wdata", WDATA, 0);
    chk("rst_wstrb", WSTRB, 0);
    @(negedge ACLK) ARESETn = 1;
    @(posedge ACLK); #1;

    run_txn(1, 8'h04, 32'hDEADBEEF, 4'hF,
            0, 0, 2, 0, 0, 2'b00, 0);
    run_txn(1, 8'h10, 32'hA5A5_0F0F, 4'h3,
            4, 1, 0, 0, 0, 2'b00, 0);
    run_txn(0, 8'h08, 0, 4'h0,
            4, 0, 0, 0, 0, 2'b10, 32'h12345678);
    run_txn(0, 8'h2C, 0, 4'h0,
            2, 0, 3, 0, 1, 2'b00, 32'hCAFE0001);
    run_txn(1, 8'h30, 32'h0BAD_F00D, 4'hC,
            1, 0, 1, 0, 0, 2'b11, 0);
    run_txn(1, 8'h44, 32'h1111_2222, 4'h1,
            12, 2, 3, 0, 0, 2'b00, 0);
    run_txn(0, 8'h48, 0, 4'h0,
            0, 0, 0, 0, 0, 2'b01, 32'h5555AAAA);
    run_txn(1, 8'h50, 32'h7777_8888, 4'h6,
            3, 3, 0, 1, 0, 2'b00, 0);

    for (int i = 0; i < 40; i++) begin
      r_wr = 1'($urandom);
      r_a = AW'($urandom);
      r_d = $urandom; r_rd = $urandom;
      r_s = 4'($urandom);
      r_rsp = 2'($urandom);
      r_da = ($urandom_range(0, 5) == 0) ?
             $urandom_range(8, 12) :
             $urandom_range(0, 4);
      r_dw = $urandom_range(0, 4);
      r_dr = $urandom_range(0, 3);
      r_eb = ($urandom_range(0, 3) == 0);
      r_hold = 1'($urandom);
      run_txn(r_wr, r_a, r_d, r_s, r_da, r_dw,
              r_dr, r_eb, r_hold, r_rsp, r_rd);
    end

    transfer = 1; write = 1; addr = 8'h3C;
    wdata = 32'hFEEDFACE; wstrb = 4'hA;
    AWREADY = 1; WREADY = 1;
    @(posedge ACLK); #1;
    transfer = 0;
    @(posedge ACLK); #1;
    AWREADY = 0; WREADY = 0;
    chk("rst6_bready_pre", BREADY, 1);
    #2 ARESETn = 0;
    #1;
    chk("rst6_bready", BREADY, 0);
    chk("rst6_busy", busy, 0);
    chk("rst6_awvalid", AWVALID, 0);
    chk("rst6_rdata", rdata, 0);
    chk("rst6_awaddr", AWADDR, 0);
    last_rdata = 0;
    @(negedge ACLK) ARESETn = 1;
    @(posedge ACLK); #1;
    chk("rst6_idle_busy", busy, 0);
    run_txn(1, 8'h60, 32'h600D_CAFE, 4'h9,
            1, 2, 1, 0, 0, 2'b00, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
